// File: rtl/hdmi_rx_window_capture.sv
// HDMI receive window capture: writes a configurable rectangle of each decoded
// frame to the capture FIFO, single-shot or continuous, with sticky error flags.
module hdmi_rx_window_capture #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int CHANNELS     = 3,
    parameter int CNT_WIDTH    = 12,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_hsync,
    input  logic                            i_vsync,
    input  logic                            i_de,
    input  logic [CHANNELS-1:0]             i_chan_vld,
    input  logic [CHANNELS-1:0]             i_chan_rdy,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0] i_pixel_in,
    input  logic [CNT_WIDTH-1:0]            i_cfg_x_start,
    input  logic [CNT_WIDTH-1:0]            i_cfg_y_start,
    input  logic [CNT_WIDTH-1:0]            i_cfg_width,
    input  logic [CNT_WIDTH-1:0]            i_cfg_height,
    input  logic                            i_continuous,
    input  logic                            i_start,
    input  logic                            i_abort,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] o_fifo_data,
    output logic                            o_fifo_wr_en,
    input  logic                            i_fifo_full,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_overflow,
    output logic                            o_link_err,
    output logic                            o_short_frame,
    output logic [15:0]                     o_frame_count,
    output logic [2:0]                      o_state
);
    localparam int CW1 = CNT_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_LINK  = 3'd1,
        S_WAIT_FRAME = 3'd2,
        S_ACTIVE     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                 r_state, w_next;
    logic                   r_vsync_q, r_de_q;
    logic [CNT_WIDTH-1:0]   r_x, r_y;
    logic [CNT_WIDTH-1:0]   r_xs, r_ys, r_w, r_h;
    logic                   r_cont;

    logic                   w_link_ready, w_frame_start, w_line_end;
    logic [CW1-1:0]         w_x_end, w_y_end;
    logic                   w_in_win, w_win_done, w_wr, w_drop;
    logic                   w_set_link, w_set_short;
    logic                   w_unused_hsync;

    assign w_unused_hsync = i_hsync;

    assign w_link_ready  = (&i_chan_vld) & (&i_chan_rdy);
    assign w_frame_start = (i_vsync == VSYNC_ACTIVE) && (r_vsync_q != VSYNC_ACTIVE);
    assign w_line_end    = r_de_q && !i_de;

    // Bounds carry one extra bit so start+size never wraps.
    assign w_x_end    = {1'b0, r_xs} + {1'b0, r_w};
    assign w_y_end    = {1'b0, r_ys} + {1'b0, r_h};
    assign w_in_win   = (r_state == S_ACTIVE) && i_de &&
                        (r_x >= r_xs) && ({1'b0, r_x} < w_x_end) &&
                        (r_y >= r_ys) && ({1'b0, r_y} < w_y_end);
    assign w_win_done = w_line_end && (({1'b0, r_y} + CW1'(1)) == w_y_end);

    // Abort and link loss both suppress the write sampled in the same cycle.
    assign w_wr   = w_in_win && !i_abort && w_link_ready && !i_fifo_full;
    assign w_drop = w_in_win && !i_abort && w_link_ready &&  i_fifo_full;

    always_comb begin
        w_next      = r_state;
        w_set_link  = 1'b0;
        w_set_short = 1'b0;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (i_start) w_next = S_WAIT_LINK;
                S_WAIT_LINK: if (w_link_ready) w_next = S_WAIT_FRAME;
                S_WAIT_FRAME: begin
                    if (!w_link_ready) begin
                        w_next     = S_WAIT_LINK;
                        w_set_link = 1'b1;
                    end else if (w_frame_start) begin
                        w_next = (r_w == '0 || r_h == '0) ? S_DONE : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (!w_link_ready) begin
                        w_next     = S_WAIT_LINK;
                        w_set_link = 1'b1;
                    end else if (w_frame_start) begin
                        w_next      = S_DONE;
                        w_set_short = 1'b1;
                    end else if (w_win_done) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE:  w_next = r_cont ? S_WAIT_FRAME : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_vsync_q     <= 1'b0;
            r_de_q        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_xs          <= '0;
            r_ys          <= '0;
            r_w           <= '0;
            r_h           <= '0;
            r_cont        <= 1'b0;
            o_fifo_data   <= '0;
            o_fifo_wr_en  <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_link_err    <= 1'b0;
            o_short_frame <= 1'b0;
            o_frame_count <= '0;
        end else begin
            r_state      <= w_next;
            r_vsync_q    <= i_vsync;
            r_de_q       <= i_de;
            o_fifo_wr_en <= w_wr;
            o_done       <= 1'b0;
            if (w_wr) o_fifo_data <= i_pixel_in;

            if (r_state == S_IDLE && i_start && !i_abort) begin
                r_xs          <= i_cfg_x_start;
                r_ys          <= i_cfg_y_start;
                r_w           <= i_cfg_width;
                r_h           <= i_cfg_height;
                r_cont        <= i_continuous;
                o_overflow    <= 1'b0;
                o_link_err    <= 1'b0;
                o_short_frame <= 1'b0;
                o_frame_count <= '0;
            end
            if (w_drop)      o_overflow    <= 1'b1;
            if (w_set_link)  o_link_err    <= 1'b1;
            if (w_set_short) o_short_frame <= 1'b1;
            if (r_state == S_DONE && !i_abort) begin
                o_done        <= 1'b1;
                o_frame_count <= o_frame_count + 16'd1;
            end

            if (r_state == S_WAIT_FRAME && w_next == S_ACTIVE) begin
                r_x <= '0;
                r_y <= '0;
            end else if (r_state == S_ACTIVE) begin
                if (w_line_end) begin
                    r_x <= '0;
                    r_y <= r_y + CNT_WIDTH'(1);
                end else if (i_de && r_x != '1) begin
                    r_x <= r_x + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

endmodule

// File: tb/tb_hdmi_rx_window_capture.sv
// Directed bench for hdmi_rx_window_capture: drives synthetic 16x8 frames and
// checks written pixels, done pulses, sticky flags and state against hand values.
module tb_hdmi_rx_window_capture;
    logic        clk = 1'b0;
    logic        rst, hsync, vsync, de, continuous, start, abort, fifo_full;
    logic [2:0]  chan_vld, chan_rdy;
    logic [23:0] pixel_in, fifo_data;
    logic [11:0] cfg_x_start, cfg_y_start, cfg_width, cfg_height;
    logic        fifo_wr_en, busy, done, overflow, link_err, short_frame;
    logic [15:0] frame_count;
    logic [2:0]  state;

    int n_assert = 0, n_fail = 0;
    int n_done = 0, cont_bad = 0;
    bit mon_cont = 0;
    logic [23:0] got[$], expq[$];

    int full_y = -1, full_x0 = 0, full_n = 0;
    int drop_line = -1, drop_col = 0;
    int abort_line = -1, abort_col = 0;
    int start_line = -1;
    int snap_line = -1, snap_col = 0;
    logic [2:0] snap_state;
    logic       snap_wr;

    always #5 clk = ~clk;

    hdmi_rx_window_capture dut (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync), .i_de(de),
        .i_chan_vld(chan_vld), .i_chan_rdy(chan_rdy), .i_pixel_in(pixel_in),
        .i_cfg_x_start(cfg_x_start), .i_cfg_y_start(cfg_y_start),
        .i_cfg_width(cfg_width), .i_cfg_height(cfg_height),
        .i_continuous(continuous), .i_start(start), .i_abort(abort),
        .o_fifo_data(fifo_data), .o_fifo_wr_en(fifo_wr_en), .i_fifo_full(fifo_full),
        .o_busy(busy), .o_done(done), .o_overflow(overflow), .o_link_err(link_err),
        .o_short_frame(short_frame), .o_frame_count(frame_count), .o_state(state)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en) got.push_back(fifo_data);
            if (done) n_done++;
            if (mon_cont && !(state inside {3'd2, 3'd3, 3'd4})) cont_bad++;
        end
    end

    function automatic logic [23:0] pix(int l, int c);
        return {8'(l), 8'(c), 8'hC3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input int xs, input int ys, input int w, input int h,
                             input int fy, input int fx0, input int fn, input int maxn);
        int n = 0;
        for (int y = ys; y < ys + h; y++)
            for (int x = xs; x < xs + w; x++)
                if (n < maxn && !(y == fy && x >= fx0 && x < fx0 + fn)) begin
                    expq.push_back(pix(y, x));
                    n++;
                end
    endtask

    task automatic cmp_data(input string tag);
        chk({tag, "_nwr"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk({tag, "_px"}, got[i], expq[i]);
    endtask

    // 16x8 active frame: vsync pulse, blanking, 8 lines of 16 de cycles.
    task automatic frame();
        vsync = 1'b1; tick(); tick();
        vsync = 1'b0; tick(); tick(); tick();
        for (int l = 0; l < 8; l++) begin
            hsync = 1'b0;
            for (int c = 0; c < 16; c++) begin
                de        = 1'b1;
                pixel_in  = pix(l, c);
                fifo_full = (l == full_y && c >= full_x0 && c < full_x0 + full_n);
                chan_rdy  = (l == drop_line && c >= drop_col && c < drop_col + 2) ? 3'b101 : 3'b111;
                abort     = (l == abort_line && c == abort_col);
                start     = (l == start_line && c == 0);
                tick();
                if (l == snap_line && c == snap_col) begin
                    snap_state = state;
                    snap_wr    = fifo_wr_en;
                end
            end
            de = 1'b0; fifo_full = 1'b0; chan_rdy = 3'b111; abort = 1'b0; start = 1'b0;
            hsync = 1'b1;
            repeat (4) tick();
        end
        tick(); tick();
    endtask

    task automatic arm(input int xs, input int ys, input int w, input int h, input logic cont);
        cfg_x_start = 12'(xs); cfg_y_start = 12'(ys);
        cfg_width = 12'(w); cfg_height = 12'(h); continuous = cont;
        got.delete(); expq.delete(); n_done = 0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hsync = 0; vsync = 0; de = 0; continuous = 0; start = 0; abort = 0;
        fifo_full = 0; chan_vld = 3'b111; chan_rdy = 3'b111; pixel_in = '0;
        cfg_x_start = 0; cfg_y_start = 0; cfg_width = 0; cfg_height = 0;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_flags", {done, overflow, link_err, short_frame}, 0);
        chk("rst_count", frame_count, 0);
        rst = 1'b0; tick();

        // single shot; config scrambled after arming must not matter
        arm(4, 2, 8, 3, 1'b0);
        chk("t1_wait_link", state, 1);
        cfg_x_start = 0; cfg_y_start = 0; cfg_width = 1; cfg_height = 1; continuous = 1;
        tick();
        chk("t1_wait_frame", state, 2);
        chk("t1_busy", busy, 1);
        frame(); repeat (3) tick();
        build_exp(4, 2, 8, 3, -1, 0, 0, 999);
        cmp_data("t1");
        chk("t1_done", n_done, 1);
        chk("t1_count", frame_count, 1);
        chk("t1_state", state, 0);
        chk("t1_ovf", overflow, 0);

        // continuous, three frames
        arm(4, 2, 8, 3, 1'b1);
        chk("t2_count_clr", frame_count, 0);
        tick(); mon_cont = 1;
        frame(); frame(); frame(); repeat (3) tick();
        mon_cont = 0;
        for (int k = 0; k < 3; k++) build_exp(4, 2, 8, 3, -1, 0, 0, 999);
        cmp_data("t2");
        chk("t2_done", n_done, 3);
        chk("t2_count", frame_count, 3);
        chk("t2_state_range", cont_bad, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t2_abort_idle", state, 0);
        chk("t2_abort_nodone", n_done, 3);

        // fifo_full over five in-window pixels of line 3
        arm(4, 2, 8, 3, 1'b0); tick();
        full_y = 3; full_x0 = 6; full_n = 5;
        frame(); repeat (3) tick();
        full_y = -1;
        build_exp(4, 2, 8, 3, 3, 6, 5, 999);
        cmp_data("t3");
        chk("t3_ovf", overflow, 1);
        chk("t3_done", n_done, 1);

        // start mid-frame: wait for next vsync edge
        cfg_x_start = 4; cfg_y_start = 2; cfg_width = 8; cfg_height = 3; continuous = 0;
        got.delete(); expq.delete(); n_done = 0;
        start_line = 3;
        frame();
        start_line = -1;
        chk("t4_no_early_wr", got.size(), 0);
        chk("t4_waiting", state, 2);
        chk("t4_ovf_clr", overflow, 0);
        frame(); repeat (3) tick();
        build_exp(4, 2, 8, 3, -1, 0, 0, 999);
        cmp_data("t4");
        chk("t4_done", n_done, 1);

        // link loss in ACTIVE
        arm(4, 2, 8, 3, 1'b0); tick();
        drop_line = 3; drop_col = 8; snap_line = 3; snap_col = 8;
        frame();
        drop_line = -1; snap_line = -1;
        chk("t5_state_link", snap_state, 1);
        chk("t5_link_err", link_err, 1);
        chk("t5_partial", got.size(), 12);
        chk("t5_no_done", n_done, 0);
        frame(); repeat (3) tick();
        build_exp(4, 2, 8, 3, -1, 0, 0, 12);
        build_exp(4, 2, 8, 3, -1, 0, 0, 999);
        cmp_data("t5");
        chk("t5_done", n_done, 1);
        chk("t5_link_sticky", link_err, 1);

        // window runs off the bottom of the frame
        arm(4, 6, 8, 4, 1'b0); tick();
        frame(); frame(); repeat (3) tick();
        build_exp(4, 6, 8, 4, -1, 0, 0, 16);
        cmp_data("t6");
        chk("t6_short", short_frame, 1);
        chk("t6_done", n_done, 1);
        chk("t6_state", state, 0);

        // abort mid-window
        arm(4, 2, 8, 3, 1'b0); tick();
        abort_line = 3; abort_col = 8; snap_line = 3; snap_col = 8;
        frame(); repeat (3) tick();
        abort_line = -1; snap_line = -1;
        chk("t7_state", snap_state, 0);
        chk("t7_wr", snap_wr, 0);
        build_exp(4, 2, 8, 3, -1, 0, 0, 12);
        cmp_data("t7");
        chk("t7_no_done", n_done, 0);
        chk("t7_count", frame_count, 0);
        chk("t7_short_clr", short_frame, 0);

        // zero width: straight to done, nothing written
        arm(4, 2, 0, 3, 1'b0); tick();
        frame(); repeat (3) tick();
        chk("t8_nwr", got.size(), 0);
        chk("t8_done", n_done, 1);
        chk("t8_count", frame_count, 1);
        chk("t8_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_rx_window_capture.md
Name: hdmi_rx_window_capture

Overview:
- Parametrised successor to the HDMI receive capture stage.
- Sits between the TMDS decoder outputs (sync, de, per-channel pixel data and valid/ready) and the capture FIFO.
- Captures a runtime-configurable rectangular window of each frame, in single-shot or continuous mode.
- Reports FIFO overflow, link loss and truncated frames, and keeps a count of completed frames.

Parameters:
- PIXEL_WIDTH, 8, bits per colour channel
- CHANNELS, 3, number of colour channels; data packed channel CHANNELS-1 at MSB (red, green, blue for 3)
- CNT_WIDTH, 12, width of the x/y counters and window config fields
- VSYNC_ACTIVE, 1, level of vsync that marks the sync pulse; the frame starts on the transition into this level

Ports:
- clk  in  1  regenerated pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- hsync  in  1  decoded hsync
- vsync  in  1  decoded vsync
- de  in  1  data enable
- chan_vld  in  CHANNELS  per-channel decoder valid
- chan_rdy  in  CHANNELS  per-channel decoder ready
- pixel_in  in  CHANNELS*PIXEL_WIDTH  packed pixel data
- cfg_x_start  in  CNT_WIDTH  first captured column (0-based de count within a line)
- cfg_y_start  in  CNT_WIDTH  first captured line (0-based active-line count)
- cfg_width  in  CNT_WIDTH  window width in pixels
- cfg_height  in  CNT_WIDTH  window height in lines
- continuous  in  1  1 = re-arm after each frame, 0 = single shot
- start  in  1  one-cycle request to arm
- abort  in  1  one-cycle request to stop
- fifo_data  out  CHANNELS*PIXEL_WIDTH  registered pixel to FIFO
- fifo_wr_en  out  1  write strobe
- fifo_full  in  1  FIFO full
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse per completed window
- overflow  out  1  sticky; a pixel was dropped because fifo_full was high
- link_err  out  1  sticky; link_ready dropped during WAIT_FRAME or ACTIVE
- short_frame  out  1  sticky; frame start arrived before the window completed
- frame_count  out  16  windows completed since start; wraps
- state  out  3  current state encoding for debug/LEDs

Behaviour:
- Reset: state = IDLE; all outputs 0; counters 0; latched config 0.
- link_ready = AND of all chan_vld and chan_rdy bits.
- vsync and de are registered once (vsync_q, de_q).
  - frame_start = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE).
  - line_end = de_q && !de.
- States and encodings:
  - IDLE (0): on start, latch all cfg_* and continuous; clear overflow, link_err, short_frame and frame_count; go to WAIT_LINK. start is ignored in every other state.
  - WAIT_LINK (1): when link_ready is high, go to WAIT_FRAME.
  - WAIT_FRAME (2): on frame_start, clear x and y, go to ACTIVE. If the latched width or height is 0, go straight to DONE with no writes. Never enter ACTIVE mid-frame.
  - ACTIVE (3):
    - x increments on each de cycle and saturates at all-ones.
    - On line_end, x clears and y increments.
    - Pixel is in window when x_start <= x < x_start+width and y_start <= y < y_start+height.
    - Bounds are compared at CNT_WIDTH+1 bits so the sums never wrap.
    - Window complete (line_end with y == y_start+height-1): go to DONE.
    - frame_start before completion: set short_frame, go to DONE.
  - DONE (4): pulse done for one cycle and increment frame_count. If continuous, go to WAIT_FRAME; otherwise go to IDLE.
- Write path, latency 1:
  - fifo_wr_en(t+1) = in-window de at t AND !fifo_full at t; fifo_data(t+1) = pixel_in(t).
  - An in-window pixel seen while fifo_full is high is dropped and sets overflow. There is no retry.
  - fifo_data holds its last value when fifo_wr_en is 0.
- link_ready low in WAIT_FRAME or ACTIVE: set link_err, go to WAIT_LINK; fifo_wr_en is 0 from the next cycle. Latched config is kept.
- abort: takes effect in any state the same cycle it is sampled; next state is IDLE; fifo_wr_en is 0 next cycle; no done pulse. Sticky flags are kept until the next start.
- Simultaneous events, priority order: rst > abort > link loss > frame_start > line_end.
- Config inputs may change freely while busy; only the values latched at start are used.

Test Plan:
- 16x8 active frame, window x=4 y=2 w=8 h=3, single shot, fifo_full=0 -> exactly 24 writes of the correct pixels; done pulses once; frame_count=1; state returns to 0.
- Same window, continuous=1, 3 frames -> 72 writes; 3 done pulses; frame_count=3; state stays in {2,3,4}.
- fifo_full held high for 5 in-window cycles -> 5 pixels missing; overflow=1; remaining writes unaffected.
- start asserted mid-frame (vsync inactive, de toggling) -> no writes until the next vsync edge, then a clean window.
- chan_rdy[1] dropped for 2 cycles in ACTIVE -> link_err=1; state=1; no writes until relock plus the next frame_start.
- Window y=6 h=4 on an 8-line frame -> short_frame=1; done pulses; 2 lines written. Separately, abort mid-window -> state 0 next cycle; fifo_wr_en=0; no done pulse.
